reg_dump_reader: RTL

- Debug/verification block that walks a contiguous range of the 64-bit integer register file through one combinational read port.
- Streams each register value out over a valid/ready interface, tagged with its index.
- Accumulates an XOR checksum of all words sent.
- Sits beside the register file. The core is stalled via busy while a dump runs, so the block owns the read port during that time.

---
 rtl/reg_dump_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks registers FIRST_REG..LAST_REG through a combinational
// register-file read port and streams each value out over valid/ready, tagged
// with its index, while accumulating an XOR checksum of the words accepted.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start, abort    begin a dump (IDLE only) / cancel a dump in progress
//   rf_addr, rf_re  register-file read index and port-ownership enable
//   rf_data         combinational read data for rf_addr
//   out_valid/out_ready/out_data/out_index   output word stream
//   busy            dump in progress (core must stall)
//   done            one-cycle pulse after the last word is accepted
//   checksum        XOR of all words accepted in the current or last dump
module reg_dump_reader #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_re,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                re_d;
  logic                valid_d;
  logic [DATA_W-1:0]   data_d;
  logic [ADDR_W-1:0]   index_d;
  logic                busy_d;
  logic                done_d;
  logic [DATA_W-1:0]   sum_d;

  // State and all outputs are registered; rf_addr doubles as the walk index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rf_addr   <= '0;
      rf_re     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      state_q   <= state_d;
      rf_addr   <= addr_d;
      rf_re     <= re_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_index <= index_d;
      busy      <= busy_d;
      done      <= done_d;
      checksum  <= sum_d;
    end
  end

  // Next state and next registered-output values.
  always_comb begin
    state_d = state_q;
    addr_d  = rf_addr;
    re_d    = 1'b0;
    valid_d = out_valid;
    data_d  = out_data;
    index_d = out_index;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = checksum;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = FIRST_IDX;
          re_d    = 1'b1;
          busy_d  = 1'b1;
          sum_d   = '0;
        end
      end

      READ: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = SEND;
          data_d  = rf_data;
          index_d = rf_addr;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      SEND: begin
        // Abort overrides a same-cycle handshake: the word is not counted.
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          busy_d = 1'b1;
          if (out_valid && out_ready) begin
            sum_d   = checksum ^ out_data;
            valid_d = 1'b0;
            if (rf_addr == LAST_IDX) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = READ;
              addr_d  = rf_addr + ADDR_W'(1);
              re_d    = 1'b1;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
